multicycle_ctrl: RTL and testbench



---
 rtl/legv8_pkg.sv | 35 +++
 rtl/legv8_opdecode.sv | 39 +++
 rtl/multicycle_ctrl.sv | 129 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: ALU operation codes, opcode patterns,
// controller state and instruction class enums.
package legv8_pkg;

  localparam logic [3:0] AluAnd   = 4'b0000;
  localparam logic [3:0] AluOr    = 4'b0001;
  localparam logic [3:0] AluAdd   = 4'b0010;
  localparam logic [3:0] AluLsl   = 4'b0011;
  localparam logic [3:0] AluLsr   = 4'b0100;
  localparam logic [3:0] AluSub   = 4'b0110;
  localparam logic [3:0] AluPassB = 4'b0111;

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpLsl  = 11'b11010011011;
  localparam logic [10:0] OpLsr  = 11'b11010011010;

  localparam logic [10:0] OpCbzVal  = 11'b10110100000;
  localparam logic [10:0] OpCbzMask = 11'b11111111000;
  localparam logic [10:0] OpBVal    = 11'b00010100000;
  localparam logic [10:0] OpBMask   = 11'b11111100000;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMemRd, StMemWr, StWb, StBranch, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsRtype, ClsLoad, ClsStore, ClsCbz, ClsB, ClsShift, ClsIllegal
  } instr_class_e;

endpackage

// File: rtl/legv8_opdecode.sv
// Combinational opcode classifier; also selects the ALU operation per instruction.
// MULTICYCLE_SHIFT_EN enables LSL/LSR decode; otherwise they classify as illegal.
module legv8_opdecode
  import legv8_pkg::*;
(
  input  logic [10:0]  opcode_i,
  output instr_class_e cls_o,
  output logic [3:0]   alu_op_o
);

  always_comb begin
    cls_o    = ClsIllegal;
    alu_op_o = AluAnd;
    if ((opcode_i & OpBMask) == OpBVal) begin
      cls_o = ClsB;
    end else if ((opcode_i & OpCbzMask) == OpCbzVal) begin
      cls_o    = ClsCbz;
      alu_op_o = AluPassB;
    end else begin
      case (opcode_i)
        OpAdd:  begin cls_o = ClsRtype; alu_op_o = AluAdd; end
        OpSub:  begin cls_o = ClsRtype; alu_op_o = AluSub; end
        OpAnd:  begin cls_o = ClsRtype; alu_op_o = AluAnd; end
        OpOrr:  begin cls_o = ClsRtype; alu_op_o = AluOr;  end
        OpLdur: begin cls_o = ClsLoad;  alu_op_o = AluAdd; end
        OpStur: begin cls_o = ClsStore; alu_op_o = AluAdd; end
`ifdef MULTICYCLE_SHIFT_EN
        OpLsl:  begin cls_o = ClsShift; alu_op_o = AluLsl; end
        OpLsr:  begin cls_o = ClsShift; alu_op_o = AluLsr; end
`endif
        default: begin
          cls_o    = ClsIllegal;
          alu_op_o = AluAnd;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing
// with ready handshakes; outputs decode from state plus the class latched at DECODE.
module multicycle_ctrl
  import legv8_pkg::*;
(
  input  logic        CLK,
  input  logic        resetl,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output logic        reg2loc,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        imem_read,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        halted
);

  state_e       state_q, state_d;
  instr_class_e cls_q, cls_d, dec_cls;
  logic [3:0]   alu_op_q, alu_op_d, dec_alu_op;

  legv8_opdecode u_opdecode (
    .opcode_i (opcode),
    .cls_o    (dec_cls),
    .alu_op_o (dec_alu_op)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q  <= StFetch;
      cls_q    <= ClsIllegal;
      alu_op_q <= AluAnd;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      alu_op_q <= alu_op_d;
    end
  end

  // Instruction class is captured only while in DECODE; later opcode changes are ignored.
  always_comb begin
    cls_d    = cls_q;
    alu_op_d = alu_op_q;
    if (state_q == StDecode) begin
      cls_d    = dec_cls;
      alu_op_d = dec_alu_op;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (imem_ready) state_d = StDecode;
      StDecode: begin
        if (dec_cls == ClsB)            state_d = StBranch;
        else if (dec_cls == ClsIllegal) state_d = StHalt;
        else                            state_d = StExec;
      end
      StExec: begin
        case (cls_q)
          ClsLoad:  state_d = StMemRd;
          ClsStore: state_d = StMemWr;
          ClsCbz:   state_d = StBranch;
          default:  state_d = StWb;
        endcase
      end
      StMemRd:  if (dmem_ready) state_d = StWb;
      StMemWr:  if (dmem_ready) state_d = StFetch;
      StWb:     state_d = StFetch;
      StBranch: state_d = StFetch;
      StHalt:   state_d = StHalt;
    endcase
  end

  // Gating on resetl forces every output low for as long as reset is held.
  always_comb begin
    alu_ctrl   = AluAnd;
    alu_src    = 1'b0;
    reg2loc    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    imem_read  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    if (resetl) begin
      // ALU controls persist from EXEC so the result stays stable downstream.
      if (state_q inside {StExec, StMemRd, StMemWr, StWb, StBranch}) begin
        alu_ctrl = alu_op_q;
        alu_src  = cls_q inside {ClsLoad, ClsStore, ClsShift};
        reg2loc  = cls_q inside {ClsStore, ClsCbz};
      end
      unique case (state_q)
        StFetch: begin
          imem_read = 1'b1;
          ir_write  = imem_ready;
          pc_write  = imem_ready;
        end
        StDecode: begin
        end
        StExec: begin
        end
        StMemRd: mem_read = 1'b1;
        StMemWr: mem_write = 1'b1;
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == ClsLoad);
        end
        StBranch: begin
          pc_src   = 1'b1;
          pc_write = (cls_q == ClsB) ? 1'b1 : zero;
        end
        StHalt: halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are
// queued by the driver and compared by an independent negedge monitor.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        resetl;
  logic [10:0] opcode;
  logic        zero, imem_ready, dmem_ready;
  logic [3:0]  alu_ctrl;
  logic        alu_src, reg2loc, ir_write, pc_write, pc_src, imem_read;
  logic        mem_read, mem_write, mem_to_reg, reg_write, halted;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .CLK        (clk),
    .resetl     (resetl),
    .opcode     (opcode),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_src    (alu_src),
    .reg2loc    (reg2loc),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .imem_read  (imem_read),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .halted     (halted)
  );

  // Output vector: {alu_ctrl, alu_src, reg2loc, ir_write, pc_write, pc_src, imem_read,
  //                 mem_read, mem_write, mem_to_reg, reg_write, halted}
  localparam logic [10:0] FSrc  = 11'h400;
  localparam logic [10:0] FR2l  = 11'h200;
  localparam logic [10:0] FIrw  = 11'h100;
  localparam logic [10:0] FPcw  = 11'h080;
  localparam logic [10:0] FPcs  = 11'h040;
  localparam logic [10:0] FImr  = 11'h020;
  localparam logic [10:0] FMr   = 11'h010;
  localparam logic [10:0] FMw   = 11'h008;
  localparam logic [10:0] FM2r  = 11'h004;
  localparam logic [10:0] FRw   = 11'h002;
  localparam logic [10:0] FHalt = 11'h001;

  typedef enum int {KRtype, KLoad, KStore, KCbz, KB, KShift, KIll} kind_e;

  logic [14:0] act;
  logic [14:0] exp_q[$];
  int          tests = 0;
  int          failures = 0;
  int          step_idx = 0;
  int          abort_at = -1;
  bit          in_rst = 1'b0;
  bit          done = 1'b0;
  int          cyc = 0;

  assign act = {alu_ctrl, alu_src, reg2loc, ir_write, pc_write, pc_src, imem_read,
                mem_read, mem_write, mem_to_reg, reg_write, halted};

  // Reference decode straight from the instruction table.
  function automatic void ref_decode(input logic [10:0] op, output kind_e k,
                                     output logic [3:0] alu);
    k   = KIll;
    alu = 4'b0000;
    if (op[10:5] == 6'b000101) begin
      k = KB;
    end else if (op[10:3] == 8'b10110100) begin
      k = KCbz; alu = 4'b0111;
    end else if (op == 11'b10001011000) begin
      k = KRtype; alu = 4'b0010;
    end else if (op == 11'b11001011000) begin
      k = KRtype; alu = 4'b0110;
    end else if (op == 11'b10001010000) begin
      k = KRtype; alu = 4'b0000;
    end else if (op == 11'b10101010000) begin
      k = KRtype; alu = 4'b0001;
    end else if (op == 11'b11111000010) begin
      k = KLoad; alu = 4'b0010;
    end else if (op == 11'b11111000000) begin
      k = KStore; alu = 4'b0010;
`ifdef MULTICYCLE_SHIFT_EN
    end else if (op == 11'b11010011011) begin
      k = KShift; alu = 4'b0011;
    end else if (op == 11'b11010011010) begin
      k = KShift; alu = 4'b0100;
`endif
    end
  endfunction

  function automatic logic [14:0] fetch_vec(input logic rdy);
    return {4'b0000, FImr | (rdy ? (FIrw | FPcw) : 11'd0)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_inputs();
    opcode     = 11'($urandom);
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    zero       = 1'($urandom);
  endtask

  // Queue this cycle's expectation; at the abort point reset drops asynchronously.
  task automatic step(input logic [14:0] e);
    if (step_idx == abort_at) begin
      resetl = 1'b0;
      in_rst = 1'b1;
    end
    exp_q.push_back(in_rst ? 15'd0 : e);
    step_idx++;
  endtask

  task automatic release_reset();
    cycle();
    rnd_inputs();
    resetl     = 1'b1;
    imem_ready = 1'b0;
    exp_q.push_back(fetch_vec(1'b0));
    in_rst = 1'b0;
  endtask

  task automatic run_instr(input logic [10:0] op, input int fs, input int ms, input logic z,
                           input int ab, input int hc);
    kind_e       k;
    logic [3:0]  alu;
    logic [10:0] bf;
    ref_decode(op, k, alu);
    bf = ((k == KLoad || k == KStore || k == KShift) ? FSrc : 11'd0) |
         ((k == KStore || k == KCbz) ? FR2l : 11'd0);
    step_idx = 0;
    abort_at = ab;
    for (int i = 0; i <= fs; i++) begin
      cycle(); rnd_inputs(); imem_ready = (i == fs);
      step(fetch_vec(imem_ready));
    end
    cycle(); rnd_inputs(); opcode = op;
    step(15'd0);
    case (k)
      KRtype, KShift: begin
        cycle(); rnd_inputs(); step({alu, bf});
        cycle(); rnd_inputs(); step({alu, bf | FRw});
      end
      KLoad: begin
        cycle(); rnd_inputs(); step({alu, bf});
        for (int i = 0; i <= ms; i++) begin
          cycle(); rnd_inputs(); dmem_ready = (i == ms);
          step({alu, bf | FMr});
        end
        cycle(); rnd_inputs(); step({alu, bf | FM2r | FRw});
      end
      KStore: begin
        cycle(); rnd_inputs(); step({alu, bf});
        for (int i = 0; i <= ms; i++) begin
          cycle(); rnd_inputs(); dmem_ready = (i == ms);
          step({alu, bf | FMw});
        end
      end
      KCbz: begin
        cycle(); rnd_inputs(); step({alu, bf});
        cycle(); rnd_inputs(); zero = z;
        step({alu, bf | FPcs | (z ? FPcw : 11'd0)});
      end
      KB: begin
        cycle(); rnd_inputs(); step({alu, bf | FPcs | FPcw});
      end
      default: begin
        for (int i = 0; i < hc; i++) begin
          cycle(); rnd_inputs(); step({4'b0000, FHalt});
        end
        // Only reset leaves HALT.
        if (!in_rst) abort_at = step_idx;
        cycle(); rnd_inputs(); step({4'b0000, FHalt});
      end
    endcase
    if (in_rst) release_reset();
  endtask

  // Monitor: pops one expectation per cycle, plus structural exclusivity checks.
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (act !== e) begin
          failures++;
          $display("FAIL outputs cycle %0d: got %b expected %b", cyc, act, e);
        end
        tests++;
        if (mem_read === 1'b1 && mem_write === 1'b1) begin
          failures++;
          $display("FAIL rd_wr_excl cycle %0d: got mem_read=1 mem_write=1 expected not both",
                   cyc);
        end
        tests++;
        if (reg_write === 1'b1 && mem_write === 1'b1) begin
          failures++;
          $display("FAIL rw_mw_excl cycle %0d: got reg_write=1 mem_write=1 expected not both",
                   cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    int          sel, fs, ms, ab, hc;
    logic [10:0] op;
    resetl = 1'b0;
    opcode = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    cycle(); exp_q.push_back(15'd0);
    cycle(); rnd_inputs(); exp_q.push_back(15'd0);
    release_reset();

    // Directed cases
    run_instr(11'b10001011000, 0, 0, 1'b0, -1, 0);   // ADD
    run_instr(11'b11111000010, 0, 3, 1'b0, -1, 0);   // LDUR, 3 stall cycles
    run_instr(11'b11111000000, 1, 2, 1'b0, -1, 0);   // STUR
    run_instr(11'b10110100101, 0, 0, 1'b1, -1, 0);   // CBZ taken
    run_instr(11'b10110100011, 0, 0, 1'b0, -1, 0);   // CBZ not taken
    run_instr(11'b00010100000, 0, 0, 1'b0, -1, 0);   // B
    run_instr(11'b00000000000, 0, 0, 1'b0, -1, 20);  // illegal -> HALT
    run_instr(11'b11010011010, 0, 0, 1'b0, -1, 5);   // LSR
    run_instr(11'b11010011011, 2, 0, 1'b0, -1, 5);   // LSL
    run_instr(11'b11001011000, 0, 0, 1'b0, 3, 0);    // SUB, reset during WB
    run_instr(11'b11111000000, 0, 2, 1'b0, 4, 0);    // STUR, reset during MEM_WR
    run_instr(11'b00010111111, 0, 0, 1'b0, 2, 0);    // B, reset during BRANCH
    run_instr(11'b10101010000, 1, 0, 1'b0, -1, 0);   // ORR
    run_instr(11'b10001010000, 0, 0, 1'b0, -1, 0);   // AND

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 10);
      case (sel)
        0: op = 11'b10001011000;
        1: op = 11'b11001011000;
        2: op = 11'b10001010000;
        3: op = 11'b10101010000;
        4: op = 11'b11111000010;
        5: op = 11'b11111000000;
        6: op = {8'b10110100, 3'($urandom)};
        7: op = 11'b11010011011;
        8: op = 11'b11010011010;
        9: op = {6'b000101, 5'($urandom)};
        default: op = 11'($urandom);
      endcase
      fs = $urandom_range(0, 3);
      ms = $urandom_range(0, 3);
      hc = $urandom_range(1, 4);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(op, fs, ms, 1'($urandom), ab, hc);
    end

    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
